// File: rtl/mem_interface_axi_gen.sv
// Load/store/fetch unit bridging the core to an AXI4-Lite slave.
// Each request is captured at accept time. The unit then runs either the
// AR/R pair or the concurrent AW/W pair followed by B. It returns
// sign/zero-extended load data or the fetched instruction.
module mem_interface_axi_gen #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          W_R,
    input  logic [1:0]          wordsize,
    input  logic                signo,
    input  logic [DATA_W-1:0]   rs1,
    input  logic [DATA_W-1:0]   rs2,
    input  logic [DATA_W-1:0]   imm,
    input  logic [ADDR_W-1:0]   pc,
    output logic                ARvalid,
    input  logic                ARready,
    output logic [ADDR_W-1:0]   ARaddr,
    output logic [2:0]          arprot,
    input  logic                Rvalid,
    output logic                RReady,
    input  logic [DATA_W-1:0]   Rdata,
    input  logic [1:0]          Rresp,
    output logic                AWvalid,
    input  logic                AWready,
    output logic [ADDR_W-1:0]   AWaddr,
    output logic [2:0]          awprot,
    output logic                Wvalid,
    input  logic                Wready,
    output logic [DATA_W-1:0]   Wdata,
    output logic [DATA_W/8-1:0] Wstrb,
    input  logic                Bvalid,
    output logic                Bready,
    input  logic [1:0]          Bresp,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   rd,
    output logic                rd_en,
    output logic [31:0]         inst,
    output logic                misaligned,
    output logic                bus_err
);

    localparam int LB     = DATA_W / 8;
    localparam int LANE_W = $clog2(LB);
    localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RADDR, S_RDATA, S_WADDR, S_WRESP, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_STORE, OP_LOAD, OP_FETCH
    } op_t;

    state_t              state_q, state_d;
    op_t                 op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic                signo_q;
    logic [2:0]          prot_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [LB-1:0]       strb_q;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                err_q, err_d;
    logic                mis_q, mis_d;
    logic                ldok_q, ldok_d;
    logic [DATA_W-1:0]   rd_q;
    logic [31:0]         inst_q;

    // Accept-time datapath
    logic [DATA_W-1:0]   sum;
    logic [ADDR_W-1:0]   acc_addr;
    logic [1:0]          acc_size;
    op_t                 acc_op;
    logic [LANE_W-1:0]   acc_lane;
    logic                acc_mis;
    logic                acc_ill;
    logic [LB-1:0]       acc_mask;
    logic [LB-1:0]       acc_strb;
    logic [DATA_W-1:0]   acc_wdata;

    // Read-return datapath
    logic [DATA_W-1:0]   rsh;
    logic [DATA_W-1:0]   ld_val;
    logic                ext;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, tmo;

    // Handshake valids/readies decode straight from state so a reset or
    // timeout drops them on the very next cycle.
    assign ARvalid    = (state_q == S_RADDR);
    assign RReady     = (state_q == S_RDATA);
    assign AWvalid    = (state_q == S_WADDR) && !aw_done_q;
    assign Wvalid     = (state_q == S_WADDR) && !w_done_q;
    assign Bready     = (state_q == S_WRESP);
    assign ARaddr     = addr_q;
    assign AWaddr     = addr_q;
    assign arprot     = prot_q;
    assign awprot     = prot_q;
    assign Wdata      = wdata_q;
    assign Wstrb      = strb_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign misaligned = done && mis_q;
    assign bus_err    = done && err_q;
    assign rd_en      = done && ldok_q;
    assign rd         = rd_q;
    assign inst       = inst_q;

    assign ar_hs = ARvalid && ARready;
    assign r_hs  = RReady && Rvalid;
    assign aw_hs = AWvalid && AWready;
    assign w_hs  = Wvalid && Wready;
    assign b_hs  = Bready && Bvalid;
    assign tmo   = (TIMEOUT != 0) && (timer_q == TMR_W'(TIMEOUT - 1));

    // Decode the incoming request: address, size, alignment, lane strobes and replicated store data.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        sum       = rs1 + imm;
        acc_op    = W_R[1] ? OP_FETCH : (W_R[0] ? OP_LOAD : OP_STORE);
        acc_addr  = (acc_op == OP_FETCH) ? pc : sum[ADDR_W-1:0];
        acc_size  = (acc_op == OP_FETCH) ? 2'b10 : wordsize;
        acc_lane  = acc_addr[LANE_W-1:0];
        acc_mis   = 1'b0;
        acc_mask  = '0;
        acc_wdata = '0;
        case (acc_size)
            2'b01:   acc_mis = acc_addr[0];
            2'b10:   acc_mis = |acc_addr[1:0];
            2'b11:   acc_mis = |acc_addr[2:0];
            default: acc_mis = 1'b0;
        endcase
        acc_ill = (acc_op != OP_FETCH) && (wordsize == 2'b11) && (DATA_W == 32);
        for (int i = 0; i < LB; i++) begin
            acc_mask[i] = (i < (1 << acc_size));
            case (acc_size)
                2'b00:   acc_wdata[8*i +: 8] = rs2[7:0];
                2'b01:   acc_wdata[8*i +: 8] = rs2[8*(i%2) +: 8];
                2'b10:   acc_wdata[8*i +: 8] = rs2[8*(i%4) +: 8];
                default: acc_wdata[8*i +: 8] = rs2[8*i +: 8];
            endcase
        end
        acc_strb = acc_mask << acc_lane;
    end

    // Align the returned beat to the addressed lane and extend it to full width.
    always_comb begin
        rsh    = Rdata >> {addr_q[LANE_W-1:0], 3'b000};
        ld_val = rsh;
        case (size_q)
            2'b00:   ext = signo_q && rsh[7];
            2'b01:   ext = signo_q && rsh[15];
            2'b10:   ext = signo_q && rsh[31];
            default: ext = 1'b0;
        endcase
        for (int j = 0; j < DATA_W; j++) begin
            if (j >= (8 << size_q)) ld_val[j] = ext;
        end
    end

    // Next-state logic, per-state timeout and completion status flags.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 1'b1;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        mis_d     = mis_q;
        ldok_d    = ldok_q;
        case (state_q)
            S_IDLE: begin
                err_d  = 1'b0;
                mis_d  = 1'b0;
                ldok_d = 1'b0;
                if (enable) begin
                    if (acc_ill) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else if (acc_mis) begin
                        state_d = S_DONE;
                        mis_d   = 1'b1;
                    end else if (acc_op == OP_STORE) begin
                        state_d   = S_WADDR;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d = S_RADDR;
                    end
                end
            end
            S_RADDR: begin
                if (ar_hs) begin
                    state_d = S_RDATA;
                end else if (tmo) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_RDATA: begin
                if (r_hs) begin
                    state_d = S_DONE;
                    if (Rresp != 2'b00) err_d = 1'b1;
                    else ldok_d = (op_q == OP_LOAD);
                end else if (tmo) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_WADDR: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = S_WRESP;
                end else if (tmo) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_WRESP: begin
                if (b_hs) begin
                    state_d = S_DONE;
                    err_d   = (Bresp != 2'b00);
                end else if (tmo) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) timer_d = '0;
    end

    // State and datapath registers; request fields latch only on accept.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= OP_STORE;
            addr_q    <= '0;
            size_q    <= '0;
            signo_q   <= 1'b0;
            prot_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            timer_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            mis_q     <= 1'b0;
            ldok_q    <= 1'b0;
            rd_q      <= '0;
            inst_q    <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            mis_q     <= mis_d;
            ldok_q    <= ldok_d;
            if (state_q == S_IDLE && enable) begin
                op_q    <= acc_op;
                addr_q  <= acc_addr;
                size_q  <= acc_size;
                signo_q <= signo;
                prot_q  <= (acc_op == OP_FETCH) ? 3'b100 : 3'b000;
                wdata_q <= acc_wdata;
                strb_q  <= acc_strb;
            end
            if (state_q == S_RDATA && r_hs && Rresp == 2'b00) begin
                if (op_q == OP_FETCH) inst_q <= rsh[31:0];
                else rd_q <= ld_val;
            end
        end
    end

endmodule

// File: tb/tb_mem_interface_axi_gen.sv
// Directed bench for mem_interface_axi_gen (32-bit bus, TIMEOUT=8).
// A hand-driven AXI4-Lite slave is used, and expected values are computed by hand.
module tb_mem_interface_axi_gen;

    logic        clock, reset, enable, signo;
    logic [1:0]  W_R, wordsize;
    logic [31:0] rs1, rs2, imm, pc;
    logic        ARvalid, ARready, Rvalid, RReady;
    logic        AWvalid, AWready, Wvalid, Wready, Bvalid, Bready;
    logic [31:0] ARaddr, AWaddr, Wdata, Rdata, rd, inst;
    logic [2:0]  arprot, awprot;
    logic [3:0]  Wstrb;
    logic [1:0]  Rresp, Bresp;
    logic        busy, done, rd_en, misaligned, bus_err;

    int n_cmp = 0;
    int n_bad = 0;
    int ar_cycles = 0;

    mem_interface_axi_gen #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .W_R(W_R),
        .wordsize(wordsize), .signo(signo), .rs1(rs1), .rs2(rs2), .imm(imm),
        .pc(pc), .ARvalid(ARvalid), .ARready(ARready), .ARaddr(ARaddr),
        .arprot(arprot), .Rvalid(Rvalid), .RReady(RReady), .Rdata(Rdata),
        .Rresp(Rresp), .AWvalid(AWvalid), .AWready(AWready), .AWaddr(AWaddr),
        .awprot(awprot), .Wvalid(Wvalid), .Wready(Wready), .Wdata(Wdata),
        .Wstrb(Wstrb), .Bvalid(Bvalid), .Bready(Bready), .Bresp(Bresp),
        .busy(busy), .done(done), .rd(rd), .rd_en(rd_en), .inst(inst),
        .misaligned(misaligned), .bus_err(bus_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count every cycle with ARvalid high, to prove that some accesses never touch AR.
    always @(posedge clock) if (ARvalid) ar_cycles <= ar_cycles + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one request for a single cycle, then scramble the inputs so
    // that later input changes are shown to have no effect.
    task automatic start(input logic [1:0] wr, input logic [1:0] ws, input logic sg,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] i, input logic [31:0] p);
        W_R = wr; wordsize = ws; signo = sg; rs1 = a; rs2 = b; imm = i; pc = p;
        enable = 1'b1;
        step();
        enable = 1'b0;
        W_R = 2'b00; wordsize = 2'b11; signo = ~sg;
        rs1 = 32'h5555_5555; rs2 = 32'hAAAA_AAAA; imm = 32'h3; pc = 32'h7;
    endtask

    // AR accepted after ar_dly waiting cycles, then one R beat. Ends in DONE.
    task automatic slave_read(input int ar_dly, input logic [31:0] data, input logic [1:0] resp);
        repeat (ar_dly) step();
        ARready = 1'b1;
        step();
        ARready = 1'b0;
        check("rready_up", RReady, 1);
        Rvalid = 1'b1; Rdata = data; Rresp = resp;
        step();
        Rvalid = 1'b0; Rdata = '0; Rresp = '0;
    endtask

    // AW and W readies pulse on independent cycles, then one B beat. Ends in DONE.
    task automatic slave_write(input string tag, input int aw_dly, input int w_dly, input logic [1:0] resp);
        int aw_cnt = 0, w_cnt = 0, stray = 0;
        bit aw_seen = 0, w_seen = 0;
        int last = (aw_dly > w_dly) ? aw_dly : w_dly;
        for (int c = 0; c <= last; c++) begin
            AWready = (c == aw_dly);
            Wready  = (c == w_dly);
            if ((aw_seen && AWvalid) || (w_seen && Wvalid)) stray++;
            if (AWvalid && AWready) begin aw_cnt++; aw_seen = 1; end
            if (Wvalid && Wready) begin w_cnt++; w_seen = 1; end
            step();
        end
        AWready = 1'b0; Wready = 1'b0;
        check({tag, "_aw_once"}, aw_cnt, 1);
        check({tag, "_w_once"}, w_cnt, 1);
        check({tag, "_no_stray"}, stray, 0);
        check({tag, "_bready"}, {AWvalid, Wvalid, Bready}, 3'b001);
        Bvalid = 1'b1; Bresp = resp;
        step();
        Bvalid = 1'b0; Bresp = '0;
    endtask

    initial begin
        int n;
        int ar0;
        reset = 1'b1; enable = 1'b0; W_R = '0; wordsize = '0; signo = 1'b0;
        rs1 = '0; rs2 = '0; imm = '0; pc = '0;
        ARready = 0; Rvalid = 0; Rdata = '0; Rresp = '0;
        AWready = 0; Wready = 0; Bvalid = 0; Bresp = '0;
        repeat (3) step();
        check("rst_ctl", {ARvalid, AWvalid, Wvalid, RReady, Bready, busy, done, rd_en, misaligned, bus_err}, 0);
        check("rst_rd_inst", {rd, inst}, 0);
        reset = 1'b0;
        step();

        // 1: word load ea = 0x110 + (-0x10) = 0x100, ARready two cycles late.
        start(2'b01, 2'b10, 1'b0, 32'h110, 32'h0, 32'hFFFF_FFF0, 32'h0);
        check("t1_ar", {ARvalid, busy, ARaddr, arprot}, {1'b1, 1'b1, 32'h100, 3'b000});
        slave_read(2, 32'hDEAD_BEEF, 2'b00);
        check("t1_done", {done, rd_en, bus_err, misaligned}, 4'b1100);
        check("t1_rd", rd, 32'hDEAD_BEEF);
        step();
        check("t1_idle", {done, rd_en, busy}, 3'b000);

        // 2: byte load at lane 3, signed then unsigned.
        start(2'b01, 2'b00, 1'b1, 32'h100, 32'h0, 32'h3, 32'h0);
        slave_read(0, 32'h80FF_0000, 2'b00);
        check("t2_s_rd", {rd_en, rd}, {1'b1, 32'hFFFF_FF80});
        step();
        start(2'b01, 2'b00, 1'b0, 32'h100, 32'h0, 32'h3, 32'h0);
        slave_read(0, 32'h80FF_0000, 2'b00);
        check("t2_u_rd", {rd_en, rd}, {1'b1, 32'h0000_0080});
        step();

        // 3: half store ea=0x102 under three AW/W orderings.
        start(2'b00, 2'b01, 1'b0, 32'h100, 32'h0000_1234, 32'h2, 32'h0);
        check("t3_bus", {AWaddr, awprot, Wdata, Wstrb}, {32'h102, 3'b000, 32'h1234_1234, 4'b1100});
        slave_write("t3_wfirst", 2, 0, 2'b00);
        check("t3_wfirst_done", {done, bus_err, rd_en}, 3'b100);
        step();
        start(2'b00, 2'b01, 1'b0, 32'h100, 32'h0000_1234, 32'h2, 32'h0);
        slave_write("t3_awfirst", 0, 2, 2'b00);
        check("t3_awfirst_done", {done, bus_err}, 2'b10);
        step();
        start(2'b00, 2'b01, 1'b0, 32'h100, 32'h0000_1234, 32'h2, 32'h0);
        slave_write("t3_both", 1, 1, 2'b00);
        check("t3_both_done", {done, bus_err}, 2'b10);
        step();

        // 4: misaligned word load; DONE straight after accept, AR never raised.
        ar0 = ar_cycles;
        start(2'b01, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 32'h0);
        check("t4_done", {done, misaligned, bus_err, rd_en, ARvalid}, 5'b11000);
        step();
        check("t4_no_ar", ar_cycles - ar0, 0);

        // Illegal dword size on a 32-bit bus: error and no bus access.
        start(2'b01, 2'b11, 1'b0, 32'h200, 32'h0, 32'h0, 32'h0);
        check("ill_done", {done, bus_err, misaligned}, 3'b110);
        step();
        check("ill_no_ar", ar_cycles - ar0, 0);

        // 5: SLVERR on B, then an AR timeout.
        start(2'b00, 2'b10, 1'b0, 32'h200, 32'hCAFE_F00D, 32'h0, 32'h0);
        check("t5_wbus", {Wdata, Wstrb}, {32'hCAFE_F00D, 4'b1111});
        slave_write("t5", 0, 0, 2'b10);
        check("t5_berr", {done, bus_err}, 2'b11);
        step();
        start(2'b01, 2'b10, 1'b0, 32'h300, 32'h0, 32'h0, 32'h0);
        n = 0;
        while (ARvalid && n < 20) begin
            n++;
            step();
        end
        check("t5_tmo_cycles", n, 8);
        check("t5_tmo_done", {done, bus_err, rd_en, ARvalid}, 4'b1100);
        step();

        // A load with an error R response leaves rd alone and flags bus_err.
        start(2'b01, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0);
        slave_read(0, 32'h1111_1111, 2'b11);
        check("rresp_err", {done, bus_err, rd_en, rd}, {3'b110, 32'h0000_0080});
        step();

        // 6: reset while in RDATA, then a fetch of pc=0x40.
        start(2'b01, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0);
        ARready = 1'b1;
        step();
        ARready = 1'b0;
        check("t6_in_rdata", RReady, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_rst_ctl", {ARvalid, AWvalid, Wvalid, RReady, Bready, busy, done, rd_en, misaligned, bus_err}, 0);
        check("t6_rst_data", {rd, inst, ARaddr}, 0);
        start(2'b10, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h40);
        check("t6_fetch_ar", {ARvalid, ARaddr, arprot}, {1'b1, 32'h40, 3'b100});
        slave_read(1, 32'h00A0_0093, 2'b00);
        check("t6_fetch_done", {done, rd_en, bus_err}, 3'b100);
        check("t6_inst", inst, 32'h00A0_0093);
        step();

        // A fetch that gets a DECERR must keep the previous instruction.
        start(2'b11, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 32'h44);
        slave_read(0, 32'hFFFF_FFFF, 2'b11);
        check("fetch_err", {done, bus_err, inst}, {2'b11, 32'h00A0_0093});
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
